// File: rtl/move_queue.sv
// Direction request FIFO between the button debouncers and the maze controller.
// Optional opposite-move cancellation is enabled by defining MOVE_QUEUE_CANCEL_EN.
module move_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_up,
    input  logic                     i_down,
    input  logic                     i_left,
    input  logic                     i_right,
    output logic                     o_valid,
    output logic [1:0]               o_dir,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_drop
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [1:0]    mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q;
    logic          drop_q, drop_d;
    logic [1:0]    dir_q, dir_d;

    logic [1:0]    win_dir;
    logic          push_req;
    logic          multi_req;
    logic          full;
    logic          pop;
    logic          cancel;
    logic          do_push;

    // Fixed priority: up > down > left > right.
    always_comb begin
        win_dir = 2'b11;
        if (i_up) begin
            win_dir = 2'b00;
        end else if (i_down) begin
            win_dir = 2'b01;
        end else if (i_left) begin
            win_dir = 2'b10;
        end
    end

    assign push_req  = i_up | i_down | i_left | i_right;
    assign multi_req = (i_up & (i_down | i_left | i_right)) |
                       (i_down & (i_left | i_right)) |
                       (i_left & i_right);

    assign full = (count_q == CW'(DEPTH));
    assign pop  = valid_q & i_ready;

`ifdef MOVE_QUEUE_CANCEL_EN
    logic [1:0] tail_dir;
    assign tail_dir = mem_q[wr_q - PW'(1)];
    // The tail may only be cancelled if it is not also leaving as the head this cycle.
    assign cancel = push_req && (count_q != '0) && !((count_q == CW'(1)) && pop) &&
                    (tail_dir[1] == win_dir[1]) && (tail_dir[0] != win_dir[0]);
`else
    assign cancel = 1'b0;
`endif

    assign do_push = push_req & ~cancel & (~full | pop);

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        drop_d  = multi_req;
        dir_d   = dir_q;
        if (i_clear) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
            drop_d  = push_req;
        end else begin
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            if (do_push) begin
                wr_d = wr_q + PW'(1);
            end
            if (cancel) begin
                wr_d = wr_q - PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(pop) - CW'(cancel);
            if (push_req && !cancel && full && !pop) begin
                drop_d = 1'b1;
            end
            // Head is the freshly written entry when the queue was empty after the pop.
            if (count_d != '0) begin
                dir_d = (do_push && (rd_d == wr_q)) ? win_dir : mem_q[rd_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            dir_q   <= 2'b00;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            valid_q <= (count_d != '0);
            drop_q  <= drop_d;
            dir_q   <= dir_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 2'b00;
            end
        end else if (!i_clear && do_push) begin
            mem_q[wr_q] <= win_dir;
        end
    end

    assign o_valid = valid_q;
    assign o_dir   = dir_q;
    assign o_count = count_q;
    assign o_drop  = drop_q;

endmodule

// File: tb/tb_move_queue.sv
// Directed self-checking bench for move_queue (DEPTH=4).
module tb_move_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_clear = 1'b0;
    logic       i_up = 1'b0, i_down = 1'b0, i_left = 1'b0, i_right = 1'b0;
    logic       i_ready = 1'b0;
    logic       o_valid;
    logic [1:0] o_dir;
    logic [2:0] o_count;
    logic       o_drop;

    int total = 0;
    int bad = 0;

    move_queue #(.DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_clear (i_clear),
        .i_up    (i_up),
        .i_down  (i_down),
        .i_left  (i_left),
        .i_right (i_right),
        .o_valid (o_valid),
        .o_dir   (o_dir),
        .i_ready (i_ready),
        .o_count (o_count),
        .o_drop  (o_drop)
    );

    always #5 clk = ~clk;

    // udlr = {up, down, left, right}; inputs return to idle after the edge.
    task automatic cyc(input logic [3:0] udlr, input logic rdy, input logic clr);
        {i_up, i_down, i_left, i_right} = udlr;
        i_ready = rdy;
        i_clear = clr;
        @(posedge clk);
        #1;
        {i_up, i_down, i_left, i_right} = 4'b0000;
        i_ready = 1'b0;
        i_clear = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(4'b0000, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset valid: got %b want 0", o_valid); end
        total++; if (o_dir !== 2'b00) begin bad++; $display("FAIL reset dir: got %b want 00", o_dir); end
        total++; if (o_count !== 3'd0) begin bad++; $display("FAIL reset count: got %0d want 0", o_count); end
        total++; if (o_drop !== 1'b0) begin bad++; $display("FAIL reset drop: got %b want 0", o_drop); end
    endtask

    task automatic test_single;
        cyc(4'b1000, 1'b0, 1'b0);
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL single valid: got %b want 1", o_valid); end
        total++; if (o_dir !== 2'b00) begin bad++; $display("FAIL single dir: got %b want 00", o_dir); end
        total++; if (o_count !== 3'd1) begin bad++; $display("FAIL single count: got %0d want 1", o_count); end
        total++; if (o_drop !== 1'b0) begin bad++; $display("FAIL single drop: got %b want 0", o_drop); end
        cyc(4'b0000, 1'b1, 1'b0);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL single pop valid: got %b want 0", o_valid); end
        total++; if (o_count !== 3'd0) begin bad++; $display("FAIL single pop count: got %0d want 0", o_count); end
        total++; if (o_dir !== 2'b00) begin bad++; $display("FAIL single held dir: got %b want 00", o_dir); end
    endtask

    task automatic test_order;
        logic [1:0] exp [4];
        exp[0] = 2'b11; exp[1] = 2'b10; exp[2] = 2'b01; exp[3] = 2'b00;
        cyc(4'b0001, 1'b0, 1'b0);
        cyc(4'b0010, 1'b0, 1'b0);
        cyc(4'b0100, 1'b0, 1'b0);
        cyc(4'b1000, 1'b0, 1'b0);
        total++; if (o_count !== 3'd4) begin bad++; $display("FAIL order count: got %0d want 4", o_count); end
        for (int i = 0; i < 4; i++) begin
            total++; if (o_valid !== 1'b1 || o_dir !== exp[i]) begin
                bad++; $display("FAIL order head %0d: got v=%b dir=%b want v=1 dir=%b", i, o_valid, o_dir, exp[i]);
            end
            cyc(4'b0000, 1'b1, 1'b0);
        end
        total++; if (o_valid !== 1'b0 || o_count !== 3'd0) begin
            bad++; $display("FAIL order drained: got v=%b cnt=%0d want v=0 cnt=0", o_valid, o_count);
        end
    endtask

    task automatic test_full;
        logic [1:0] exp [4];
        exp[0] = 2'b01; exp[1] = 2'b00; exp[2] = 2'b01; exp[3] = 2'b10;
        cyc(4'b1000, 1'b0, 1'b0);
        cyc(4'b0100, 1'b0, 1'b0);
        cyc(4'b1000, 1'b0, 1'b0);
        cyc(4'b0100, 1'b0, 1'b0);
        total++; if (o_count !== 3'd4) begin bad++; $display("FAIL full fill: got %0d want 4", o_count); end
        cyc(4'b0010, 1'b0, 1'b0);
        total++; if (o_drop !== 1'b1) begin bad++; $display("FAIL full drop: got %b want 1", o_drop); end
        total++; if (o_count !== 3'd4) begin bad++; $display("FAIL full drop count: got %0d want 4", o_count); end
        cyc(4'b0000, 1'b0, 1'b0);
        total++; if (o_drop !== 1'b0) begin bad++; $display("FAIL full drop pulse: got %b want 0", o_drop); end
        cyc(4'b0010, 1'b1, 1'b0);
        total++; if (o_count !== 3'd4 || o_drop !== 1'b0 || o_dir !== 2'b01) begin
            bad++; $display("FAIL full push+pop: got cnt=%0d drop=%b dir=%b want cnt=4 drop=0 dir=01", o_count, o_drop, o_dir);
        end
        for (int i = 0; i < 4; i++) begin
            total++; if (o_dir !== exp[i]) begin
                bad++; $display("FAIL full drain %0d: got %b want %b", i, o_dir, exp[i]);
            end
            cyc(4'b0000, 1'b1, 1'b0);
        end
        total++; if (o_count !== 3'd0) begin bad++; $display("FAIL full drained: got %0d want 0", o_count); end
    endtask

    task automatic test_priority;
        cyc(4'b1001, 1'b0, 1'b0);
        total++; if (o_count !== 3'd1 || o_dir !== 2'b00 || o_drop !== 1'b1) begin
            bad++; $display("FAIL priority: got cnt=%0d dir=%b drop=%b want cnt=1 dir=00 drop=1", o_count, o_dir, o_drop);
        end
        cyc(4'b0000, 1'b1, 1'b0);
        total++; if (o_drop !== 1'b0 || o_count !== 3'd0) begin
            bad++; $display("FAIL priority after: got drop=%b cnt=%0d want drop=0 cnt=0", o_drop, o_count);
        end
    endtask

    task automatic test_clear;
        cyc(4'b1000, 1'b0, 1'b0);
        cyc(4'b0010, 1'b0, 1'b0);
        cyc(4'b1000, 1'b0, 1'b0);
        total++; if (o_count !== 3'd3) begin bad++; $display("FAIL clear pre: got %0d want 3", o_count); end
        cyc(4'b0100, 1'b0, 1'b1);
        total++; if (o_count !== 3'd0 || o_valid !== 1'b0 || o_drop !== 1'b1) begin
            bad++; $display("FAIL clear: got cnt=%0d v=%b drop=%b want cnt=0 v=0 drop=1", o_count, o_valid, o_drop);
        end
        cyc(4'b0100, 1'b0, 1'b0);
        total++; if (o_dir !== 2'b01 || o_valid !== 1'b1 || o_count !== 3'd1 || o_drop !== 1'b0) begin
            bad++; $display("FAIL clear refill: got dir=%b v=%b cnt=%0d drop=%b want 01 1 1 0", o_dir, o_valid, o_count, o_drop);
        end
        cyc(4'b0000, 1'b1, 1'b1);
        total++; if (o_count !== 3'd0 || o_drop !== 1'b0) begin
            bad++; $display("FAIL clear only: got cnt=%0d drop=%b want cnt=0 drop=0", o_count, o_drop);
        end
    endtask

    task automatic test_back_to_back;
        cyc(4'b1000, 1'b1, 1'b0);
        total++; if (o_count !== 3'd1 || o_dir !== 2'b00) begin
            bad++; $display("FAIL b2b 0: got cnt=%0d dir=%b want cnt=1 dir=00", o_count, o_dir);
        end
        cyc(4'b0010, 1'b1, 1'b0);
        total++; if (o_count !== 3'd1 || o_dir !== 2'b10) begin
            bad++; $display("FAIL b2b 1: got cnt=%0d dir=%b want cnt=1 dir=10", o_count, o_dir);
        end
        cyc(4'b0100, 1'b1, 1'b0);
        total++; if (o_count !== 3'd1 || o_dir !== 2'b01) begin
            bad++; $display("FAIL b2b 2: got cnt=%0d dir=%b want cnt=1 dir=01", o_count, o_dir);
        end
        cyc(4'b0000, 1'b1, 1'b0);
        total++; if (o_count !== 3'd0 || o_valid !== 1'b0) begin
            bad++; $display("FAIL b2b drain: got cnt=%0d v=%b want 0 0", o_count, o_valid);
        end
    endtask

    task automatic test_mid_reset;
        cyc(4'b0001, 1'b0, 1'b0);
        cyc(4'b0010, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        total++; if (o_count !== 3'd0 || o_valid !== 1'b0 || o_dir !== 2'b00 || o_drop !== 1'b0) begin
            bad++; $display("FAIL mid reset: got cnt=%0d v=%b dir=%b drop=%b want 0 0 00 0", o_count, o_valid, o_dir, o_drop);
        end
    endtask

`ifdef MOVE_QUEUE_CANCEL_EN
    task automatic test_cancel;
        cyc(4'b1000, 1'b0, 1'b0);
        cyc(4'b0100, 1'b0, 1'b0);
        total++; if (o_count !== 3'd0 || o_valid !== 1'b0 || o_drop !== 1'b0) begin
            bad++; $display("FAIL cancel: got cnt=%0d v=%b drop=%b want 0 0 0", o_count, o_valid, o_drop);
        end
        cyc(4'b0010, 1'b0, 1'b0);
        cyc(4'b0001, 1'b1, 1'b0);
        total++; if (o_count !== 3'd1 || o_dir !== 2'b11) begin
            bad++; $display("FAIL cancel pop: got cnt=%0d dir=%b want cnt=1 dir=11", o_count, o_dir);
        end
        cyc(4'b0000, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
`ifndef MOVE_QUEUE_CANCEL_EN
        test_order();
        test_full();
`else
        test_cancel();
`endif
        test_priority();
        test_clear();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/move_queue.md
Name: move_queue

Overview:
- Buffers direction requests between the four button debouncers (up/down/left/right pulses) and the maze controller.
- Multiple key presses arriving while the controller is still busy with a move (ROM lookup, position update) are queued, not lost.
- Queued moves are presented one at a time as an encoded direction with a valid/ready handshake.
- A clear input empties the queue on maze restart.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- i_clear  input  1  synchronous queue flush (control-button pulse)
- i_up  input  1  one-cycle debounced pulse
- i_down  input  1  one-cycle debounced pulse
- i_left  input  1  one-cycle debounced pulse
- i_right  input  1  one-cycle debounced pulse
- o_valid  output  1  queue head holds a move
- o_dir  output  2  head direction: 00 up, 01 down, 10 left, 11 right
- i_ready  input  1  maze controller accepts head this cycle
- o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- o_drop  output  1  one-cycle pulse when a request is discarded

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: o_valid=0, o_dir=00, o_count=0, o_drop=0; read/write pointers=0.
- Storage: circular buffer with DEPTH entries of 2 bits.
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Occupancy is tracked in a separate counter.
- Push request: OR of the four pulses.
  - When more than one pulse is high in the same cycle, priority is up > down > left > right.
  - Only the winner is considered; each loser sets o_drop for that cycle.
- Pop: occurs when o_valid && i_ready. The head is released and the read pointer advances.
  - i_ready while o_valid=0 is ignored.
- First-word-fall-through: o_dir always shows the head entry while o_valid=1. When o_valid=0, o_dir is held at its last value.
- Latency: a pulse at cycle N into an empty queue gives o_valid=1 and the corresponding o_dir at cycle N+1. There is no same-cycle bypass.
- Full (count==DEPTH):
  - Push without a simultaneous pop: discarded, o_drop=1, queue unchanged.
  - Push with a simultaneous pop: both happen, count stays DEPTH.
- Empty (count==0): pop is impossible. A push in the same cycle that i_ready=1 gives count=1.
- Simultaneous push and pop when not full/empty: count unchanged, both pointers advance.
- o_valid is registered and equals (count!=0) after each update.
- i_clear:
  - Pointers and count go to 0 and o_valid to 0 on the next edge.
  - Any push or pop in the same cycle is ignored; o_drop=1 if a push was present.
  - i_clear has priority over everything except rst.
- Reset mid-operation: all contents are lost; state is identical to power-up reset.
- o_drop is a registered single-cycle pulse asserted in the cycle after the discard. It is never held high across consecutive cycles unless discards are consecutive.

Optional Feature:
- Macro: MOVE_QUEUE_CANCEL_EN.
- Defined: an incoming winning direction that is the exact opposite of the tail entry (up/down or left/right) removes the tail instead of being pushed.
  - Conditions: count>0 and the tail is not the entry being popped this cycle (i.e. not count==1 with a pop).
  - Effect: count decrements, write pointer steps back by one (with wrap), o_drop is not asserted.
  - If a pop of a different entry happens in the same cycle, count decrements by 2.
- Not defined: opposite directions are queued normally; no cancellation logic is synthesised.

Test Plan:
- Reset, then a single i_up pulse with i_ready=0 -> next cycle o_valid=1, o_dir=00, o_count=1, o_drop=0.
- Pulses right, left, down, up on consecutive cycles with i_ready=0 (cancel disabled) -> o_count=4. Then hold i_ready=1 -> o_dir sequence 11,10,01,00 on successive cycles, then o_valid=0.
- Fill to 4, one more i_left with i_ready=0 -> o_drop pulses once, o_count stays 4. Repeat i_left with i_ready=1 -> accepted, count stays 4, new tail is 10.
- i_up and i_right high in the same cycle on an empty queue -> only 00 queued, o_drop=1 one cycle later.
- Queue holding 3 entries, i_clear together with an i_down pulse -> next cycle o_count=0, o_valid=0, o_drop=1. A following i_down pulse gives o_dir=01.
- With MOVE_QUEUE_CANCEL_EN: push up, then down with i_ready=0 -> o_count returns to 0, o_drop=0. Push left, right with i_ready=1 on the right cycle -> left popped, right queued, count=1.
